// File: rtl/ivl_uvm_ovl_fire_monitor_if.sv
// ivl_uvm_ovl_fire_monitor_if: checker fire inputs, read port and status outputs of the fire monitor.
interface ivl_uvm_ovl_fire_monitor_if #(
    parameter int NUM_CHK = 4,
    parameter int CNT_W   = 8,
    parameter int TS_W    = 16
);
    localparam int IDX_W = NUM_CHK > 1 ? $clog2(NUM_CHK) : 1;
    logic                 enable;
    logic                 clr;
    logic [3*NUM_CHK-1:0] fire_bus;
    logic                 rd_req;
    logic [IDX_W-1:0]     rd_idx;
    logic                 rd_ack;
    logic [CNT_W-1:0]     rd_count;
    logic [CNT_W-1:0]     rd_xcount;
    logic                 any_fail;
    logic                 irq;
    logic                 first_vld;
    logic [IDX_W-1:0]     first_idx;
    logic [TS_W-1:0]      first_ts;
    modport master (
        output enable, clr, fire_bus, rd_req, rd_idx,
        input  rd_ack, rd_count, rd_xcount, any_fail, irq, first_vld, first_idx, first_ts
    );
    modport slave (
        input  enable, clr, fire_bus, rd_req, rd_idx,
        output rd_ack, rd_count, rd_xcount, any_fail, irq, first_vld, first_idx, first_ts
    );
endinterface

// File: rtl/ivl_uvm_ovl_fire_monitor.sv
// ivl_uvm_ovl_fire_monitor: counts OVL checker fires, captures the first failure and
// serves per-checker counts over a one-outstanding req/ack read port.
module ivl_uvm_ovl_fire_monitor #(
    parameter int NUM_CHK = 4,
    parameter int CNT_W   = 8,
    parameter int TS_W    = 16
) (
    input logic                  clock,
    input logic                  reset,
    ivl_uvm_ovl_fire_monitor_if.slave bus
);
    localparam int IDX_W = NUM_CHK > 1 ? $clog2(NUM_CHK) : 1;
    typedef enum logic {IDLE, ACK} state_t;
    state_t                          state_q, state_d;
    logic [NUM_CHK-1:0][CNT_W-1:0]   acnt_q, acnt_d, xcnt_q, xcnt_d;
    logic [TS_W-1:0]                 ts_q, ts_d, first_ts_q, first_ts_d;
    logic [IDX_W-1:0]                first_idx_q, first_idx_d;
    logic                            first_vld_q, first_vld_d, any_fail_q, any_fail_d, irq_q, irq_d;
    logic [CNT_W-1:0]                rd_count_q, rd_count_d, rd_xcount_q, rd_xcount_d;
    logic [NUM_CHK-1:0]              afire, xfire, unused_cover;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            acnt_q      <= '0;
            xcnt_q      <= '0;
            ts_q        <= '0;
            first_ts_q  <= '0;
            first_idx_q <= '0;
            first_vld_q <= 1'b0;
            any_fail_q  <= 1'b0;
            irq_q       <= 1'b0;
            rd_count_q  <= '0;
            rd_xcount_q <= '0;
        end else begin
            state_q     <= state_d;
            acnt_q      <= acnt_d;
            xcnt_q      <= xcnt_d;
            ts_q        <= ts_d;
            first_ts_q  <= first_ts_d;
            first_idx_q <= first_idx_d;
            first_vld_q <= first_vld_d;
            any_fail_q  <= any_fail_d;
            irq_q       <= irq_d;
            rd_count_q  <= rd_count_d;
            rd_xcount_q <= rd_xcount_d;
        end
    end
    always_comb begin
        for (int k = 0; k < NUM_CHK; k++) begin
            afire[k]        = bus.fire_bus[3*k];
            xfire[k]        = bus.fire_bus[3*k+1];
            unused_cover[k] = bus.fire_bus[3*k+2];
        end
        state_d     = (state_q == IDLE && bus.rd_req) ? ACK : IDLE;
        rd_count_d  = rd_count_q;
        rd_xcount_d = rd_xcount_q;
        // Read data is taken from the counters before this edge's fire updates
        if (state_q == IDLE && bus.rd_req) begin
            rd_count_d  = int'(bus.rd_idx) < NUM_CHK ? acnt_q[bus.rd_idx] : '0;
            rd_xcount_d = int'(bus.rd_idx) < NUM_CHK ? xcnt_q[bus.rd_idx] : '0;
        end
        acnt_d      = acnt_q;
        xcnt_d      = xcnt_q;
        ts_d        = ts_q + 1'b1;
        first_ts_d  = first_ts_q;
        first_idx_d = first_idx_q;
        first_vld_d = first_vld_q;
        any_fail_d  = any_fail_q;
        irq_d       = any_fail_q;
        if (bus.enable) begin
            for (int k = 0; k < NUM_CHK; k++) begin
                if (afire[k] && acnt_q[k] != '1) acnt_d[k] = acnt_q[k] + 1'b1;
                if (xfire[k] && xcnt_q[k] != '1) xcnt_d[k] = xcnt_q[k] + 1'b1;
            end
            if (|afire && !first_vld_q) begin
                first_vld_d = 1'b1;
                first_ts_d  = ts_q;
                for (int k = NUM_CHK - 1; k >= 0; k--) if (afire[k]) first_idx_d = IDX_W'(k);
            end
            any_fail_d = any_fail_q | (|afire);
        end
        if (bus.clr) begin
            acnt_d      = '0;
            xcnt_d      = '0;
            ts_d        = '0;
            first_ts_d  = '0;
            first_idx_d = '0;
            first_vld_d = 1'b0;
            any_fail_d  = 1'b0;
            irq_d       = 1'b0;
        end
    end
    assign bus.rd_ack    = state_q == ACK;
    assign bus.rd_count  = rd_count_q;
    assign bus.rd_xcount = rd_xcount_q;
    assign bus.any_fail  = any_fail_q;
    assign bus.irq       = irq_q;
    assign bus.first_vld = first_vld_q;
    assign bus.first_idx = first_idx_q;
    assign bus.first_ts  = first_ts_q;
endmodule

// File: tb/tb_ivl_uvm_ovl_fire_monitor.sv
// tb_ivl_uvm_ovl_fire_monitor: directed scenarios plus random traffic, checked every cycle
// against a behavioural model of the fire monitor.
module tb_ivl_uvm_ovl_fire_monitor;
    localparam int NC = 4, CW = 4, TW = 8;
    localparam int CMAX = (1 << CW) - 1, TMOD = 1 << TW;
    logic clock = 0, reset = 0;
    int   n_checks = 0, n_errors = 0;
    ivl_uvm_ovl_fire_monitor_if #(.NUM_CHK(NC), .CNT_W(CW), .TS_W(TW)) bus ();
    ivl_uvm_ovl_fire_monitor #(.NUM_CHK(NC), .CNT_W(CW), .TS_W(TW)) dut (
        .clock(clock), .reset(reset), .bus(bus)
    );
    always #5 clock = ~clock;

    int m_acnt[NC], m_xcnt[NC];
    int m_ts, m_any, m_irq, m_fv, m_fi, m_fts, m_ack, m_rc, m_rx;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: counts are plain saturating integers; reads see pre-edge counts
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            foreach (m_acnt[k]) begin m_acnt[k] = 0; m_xcnt[k] = 0; end
            {m_ts, m_any, m_irq, m_fv, m_fi, m_fts, m_ack, m_rc, m_rx} = '0;
        end else begin
            if (m_ack) m_ack = 0;
            else if (bus.rd_req) begin
                m_ack = 1;
                m_rc  = int'(bus.rd_idx) < NC ? m_acnt[bus.rd_idx] : 0;
                m_rx  = int'(bus.rd_idx) < NC ? m_xcnt[bus.rd_idx] : 0;
            end
            if (bus.clr) begin
                foreach (m_acnt[k]) begin m_acnt[k] = 0; m_xcnt[k] = 0; end
                {m_ts, m_any, m_irq, m_fv, m_fi, m_fts} = '0;
            end else begin
                int low;
                low = -1;
                m_irq = m_any;
                if (bus.enable) begin
                    for (int k = 0; k < NC; k++) begin
                        if (bus.fire_bus[3*k]) begin
                            m_acnt[k] = m_acnt[k] < CMAX ? m_acnt[k] + 1 : CMAX;
                            if (low < 0) low = k;
                        end
                        if (bus.fire_bus[3*k+1]) m_xcnt[k] = m_xcnt[k] < CMAX ? m_xcnt[k] + 1 : CMAX;
                    end
                    if (low >= 0) begin
                        if (!m_fv) begin m_fv = 1; m_fi = low; m_fts = m_ts; end
                        m_any = 1;
                    end
                end
                m_ts = (m_ts + 1) % TMOD;
            end
        end
    end

    initial forever begin
        @(posedge clock);
        #1;
        chk("rd_ack", bus.rd_ack, m_ack);
        chk("rd_count", bus.rd_count, m_rc);
        chk("rd_xcount", bus.rd_xcount, m_rx);
        chk("any_fail", bus.any_fail, m_any);
        chk("irq", bus.irq, m_irq);
        chk("first_vld", bus.first_vld, m_fv);
        chk("first_idx", bus.first_idx, m_fi);
        chk("first_ts", bus.first_ts, m_fts);
    end

    task automatic tick(int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic rd(int idx, int ec, int ex);
        logic [1:0] i;
        i = idx[1:0];
        @(negedge clock);
        bus.rd_req = 1;
        bus.rd_idx = i;
        @(posedge clock);
        #1;
        chk("lit_rd_ack", bus.rd_ack, 1);
        chk("lit_rd_count", bus.rd_count, ec);
        chk("lit_rd_xcount", bus.rd_xcount, ex);
        @(negedge clock);
        bus.rd_req = 0;
    endtask

    task automatic do_clr();
        @(negedge clock);
        bus.clr = 1;
        @(negedge clock);
        bus.clr = 0;
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        reset = 0;
        tick(2);
        reset = 1;
    endtask

    task automatic fire(logic [11:0] v, int n);
        @(negedge clock);
        bus.fire_bus = v;
        tick(n);
        bus.fire_bus = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int guard;
        bus.enable = 1; bus.clr = 0; bus.fire_bus = '0; bus.rd_req = 0; bus.rd_idx = '0;
        tick(3);
        reset = 1;
        // Idle after reset: nothing flagged, all counts zero
        tick(20);
        chk("lit_idle_any_fail", bus.any_fail, 0);
        chk("lit_idle_irq", bus.irq, 0);
        chk("lit_idle_first_vld", bus.first_vld, 0);
        for (int i = 0; i < NC; i++) rd(i, 0, 0);
        // Single fire on checker 1 at ts=10
        do_clr();
        guard = 0;
        while (m_ts != 10 && guard < 300) begin @(negedge clock); guard++; end
        chk("lit_ts_reach", m_ts, 10);
        bus.fire_bus = 12'h008;
        @(posedge clock);
        #1;
        chk("lit_single_any_fail", bus.any_fail, 1);
        chk("lit_single_irq_lag", bus.irq, 0);
        chk("lit_single_first_vld", bus.first_vld, 1);
        chk("lit_single_first_idx", bus.first_idx, 1);
        chk("lit_single_first_ts", bus.first_ts, 10);
        @(negedge clock);
        bus.fire_bus = '0;
        @(posedge clock);
        #1;
        chk("lit_single_irq", bus.irq, 1);
        rd(1, 1, 0);
        // Simultaneous fires on checkers 2 and 3, then checker 0
        do_clr();
        fire(12'h240, 1);
        tick(1);
        chk("lit_sim_first_idx", bus.first_idx, 2);
        fire(12'h001, 1);
        tick(1);
        chk("lit_later_first_idx", bus.first_idx, 2);
        rd(0, 1, 0);
        // Saturation and X-check only
        do_clr();
        fire(12'h001, 20);
        rd(0, 15, 0);
        pulse_reset();
        fire(12'h400, 5);
        rd(3, 0, 5);
        chk("lit_x_any_fail", bus.any_fail, 0);
        // clr on the same edge as a fire, then a fire right after clr
        fire(12'h040, 1);
        @(negedge clock);
        bus.clr = 1;
        bus.fire_bus = 12'h008;
        @(posedge clock);
        #1;
        chk("lit_clr_first_vld", bus.first_vld, 0);
        chk("lit_clr_irq", bus.irq, 0);
        chk("lit_clr_any_fail", bus.any_fail, 0);
        @(negedge clock);
        bus.clr = 0;
        @(negedge clock);
        bus.fire_bus = '0;
        chk("lit_clr_first_ts", bus.first_ts, 0);
        chk("lit_clr_first_idx", bus.first_idx, 1);
        rd(2, 0, 0);
        rd(1, 1, 0);
        // enable=0 ignores everything
        do_clr();
        bus.enable = 0;
        fire(12'hfff, 8);
        bus.enable = 1;
        tick(2);
        chk("lit_dis_any_fail", bus.any_fail, 0);
        chk("lit_dis_irq", bus.irq, 0);
        for (int i = 0; i < NC; i++) rd(i, 0, 0);
        // Reset pulse while a read is being acked
        fire(12'h008, 2);
        @(negedge clock);
        bus.rd_req = 1;
        bus.rd_idx = 2'd1;
        @(posedge clock);
        #1;
        chk("lit_ack_before_rst", bus.rd_ack, 1);
        chk("lit_ack_before_rst_cnt", bus.rd_count, 2);
        #2;
        reset = 0;
        #1;
        chk("lit_ack_async_drop", bus.rd_ack, 0);
        @(negedge clock);
        bus.rd_req = 0;
        @(negedge clock);
        reset = 1;
        rd(1, 0, 0);
        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            @(negedge clock);
            reset      = ($urandom % 400) != 0;
            bus.enable = ($urandom % 8) != 0;
            bus.clr    = ($urandom % 48) == 0;
            for (int b = 0; b < 3 * NC; b++) bus.fire_bus[b] = ($urandom % 10) == 0;
            bus.rd_req = $urandom % 2;
            bus.rd_idx = 2'($urandom % NC);
        end
        @(negedge clock);
        reset = 1;
        bus.fire_bus = '0;
        bus.rd_req = 0;
        tick(3);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
